// File: rtl/srt_divider_fp_hs_if.sv
// Operand/result handshake bundle for srt_divider_fp_hs.
// The flags member exists only when SRT_DIV_FLAGS_EN is defined.
interface srt_divider_fp_hs_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
`ifdef SRT_DIV_FLAGS_EN
    logic [4:0]   flags;
`endif

    modport master (
        output in_valid, dividend, divisor, out_ready,
`ifdef SRT_DIV_FLAGS_EN
        input  flags,
`endif
        input  in_ready, out_valid, quotient
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
`ifdef SRT_DIV_FLAGS_EN
        output flags,
`endif
        output in_ready, out_valid, quotient
    );
endinterface

// File: rtl/srt_divider_fp_hs.sv
// Iterative radix-2 SRT floating-point divider, RNE rounding, one operation in flight.
// Optional {NV,DZ,OF,UF,NX} flags output when SRT_DIV_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | in_ready=1, capture operands on in_valid
// PREP  | unpack, special-case detect, exponent difference, seed remainder
// ITER  | MAN_W+4 SRT digit iterations with on-the-fly Q/QM
// CONV  | select Q or QM, sticky from remainder, normalise to [1,2)
// ROUND | round-to-nearest-even, overflow/underflow/special mux, register result
// DONE  | out_valid=1, result held until out_ready
module srt_divider_fp_hs #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    srt_divider_fp_hs_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 4;
    localparam int R  = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N);
    localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_CONV, S_ROUND, S_DONE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]     opa_q, opb_q;
    logic             sign_q;
    logic [EW-1:0]    e_q;
    logic [R-1:0]     d_q, rem_q;
    logic [N-1:0]     q_q, qm_q;
    logic [CW-1:0]    cnt_q;
    logic             spc_q;
    logic [W-1:0]     spc_res_q;
    logic [MAN_W:0]   sig_q;
    logic             grd_q, rnd_q, stk_q;
    logic [W-1:0]     quo_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb, nv_c, s_c;
    logic [EW-1:0]    e_d;
    logic             spc_d;
    logic [W-1:0]     spc_res_d;
    logic [R-1:0]     sh, rem_nx, rem_c;
    logic             dig_pos, dig_neg, rem_neg, rem_nz;
    logic [N-1:0]     qf;
    logic             inc, carry, ovf, unf;
    logic [MAN_W+1:0] sum;
    logic [MAN_W-1:0] frac_r;
    logic [EW-1:0]    e_r;
    logic [W-1:0]     res_r;

    always_comb begin
        ea   = opa_q[W-2 -: EXP_W];
        eb   = opb_q[W-2 -: EXP_W];
        fa   = opa_q[MAN_W-1:0];
        fb   = opb_q[MAN_W-1:0];
        s_c  = opa_q[W-1] ^ opb_q[W-1];
        // subnormals have a zero exponent field and are treated as signed zero
        za   = (ea == '0);
        zb   = (eb == '0);
        ia   = (ea == EXP_ONES) && (fa == '0);
        ib   = (eb == EXP_ONES) && (fb == '0);
        na   = (ea == EXP_ONES) && (fa != '0);
        nb   = (eb == EXP_ONES) && (fb != '0);
        nv_c = na | nb | (za & zb) | (ia & ib);
        e_d  = {2'b00, ea} - {2'b00, eb} + BIAS;
        spc_d = nv_c | zb | ia | ib | za;
        if (nv_c)
            spc_res_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        else if (zb | ia)
            spc_res_d = {s_c, EXP_ONES, {MAN_W{1'b0}}};
        else
            spc_res_d = {s_c, {(W-1){1'b0}}};
    end

    // Digit from the top 3 bits of 2r (weights -2, 1, 1/2); valid because d is in [1/2, 1)
    always_comb begin
        sh      = {rem_q[R-2:0], 1'b0};
        dig_pos = !sh[R-1] && (sh[R-2] || sh[R-3]);
        dig_neg = sh[R-1] && !(sh[R-2] && sh[R-3]);
        if (dig_pos)
            rem_nx = sh - d_q;
        else if (dig_neg)
            rem_nx = sh + d_q;
        else
            rem_nx = sh;
    end

    // Corrected remainder drives sticky: a raw remainder of exactly -d means an exact QM
    always_comb begin
        rem_neg = rem_q[R-1];
        rem_c   = rem_neg ? rem_q + d_q : rem_q;
        rem_nz  = |rem_c;
        qf      = rem_neg ? qm_q : q_q;
    end

    always_comb begin
        inc    = grd_q & (rnd_q | stk_q | sig_q[0]);
        sum    = {1'b0, sig_q} + {{(MAN_W+1){1'b0}}, inc};
        carry  = sum[MAN_W+1];
        frac_r = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
        e_r    = e_q + {{(EW-1){1'b0}}, carry};
        ovf    = $signed(e_r) >= $signed(EMAX);
        unf    = e_r[EW-1] || (e_r == '0);
        if (spc_q)
            res_r = spc_res_q;
        else if (ovf)
            res_r = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        else if (unf)
            res_r = {sign_q, {(W-1){1'b0}}};
        else
            res_r = {sign_q, e_r[EXP_W-1:0], frac_r};
    end

`ifdef SRT_DIV_FLAGS_EN
    logic       dz_c, nx;
    logic [4:0] spc_flg_d, spc_flg_q, flg_r, flg_q;

    always_comb begin
        dz_c      = zb & ~ia & ~nv_c;
        spc_flg_d = {nv_c, dz_c, 3'b000};
        nx        = grd_q | rnd_q | stk_q;
        if (spc_q)
            flg_r = spc_flg_q;
        else if (ovf)
            flg_r = 5'b00101;
        else if (unf)
            flg_r = 5'b00011;
        else
            flg_r = {4'b0000, nx};
    end

    assign bus.flags = flg_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (cnt_q == '0) state_d = S_CONV;
            S_CONV:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opa_q     <= '0;
            opb_q     <= '0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            d_q       <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            qm_q      <= '0;
            cnt_q     <= '0;
            spc_q     <= 1'b0;
            spc_res_q <= '0;
            sig_q     <= '0;
            grd_q     <= 1'b0;
            rnd_q     <= 1'b0;
            stk_q     <= 1'b0;
            quo_q     <= '0;
`ifdef SRT_DIV_FLAGS_EN
            spc_flg_q <= '0;
            flg_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        opa_q <= bus.dividend;
                        opb_q <= bus.divisor;
`ifdef SRT_DIV_FLAGS_EN
                        flg_q <= '0;
`endif
                    end
                end
                S_PREP: begin
                    sign_q    <= s_c;
                    e_q       <= e_d;
                    // r0 = ma/4 and d = mb/2 keep |r| <= d, so the quotient is ma/(2*mb)
                    rem_q     <= {3'b000, 1'b1, fa};
                    d_q       <= {2'b00, 1'b1, fb, 1'b0};
                    q_q       <= '0;
                    qm_q      <= '0;
                    cnt_q     <= CW'(N - 1);
                    spc_q     <= spc_d;
                    spc_res_q <= spc_res_d;
`ifdef SRT_DIV_FLAGS_EN
                    spc_flg_q <= spc_flg_d;
`endif
                end
                S_ITER: begin
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (dig_pos) begin
                        q_q  <= {q_q[N-2:0], 1'b1};
                        qm_q <= {q_q[N-2:0], 1'b0};
                    end else if (dig_neg) begin
                        q_q  <= {qm_q[N-2:0], 1'b1};
                        qm_q <= {qm_q[N-2:0], 1'b0};
                    end else begin
                        q_q  <= {q_q[N-2:0], 1'b0};
                        qm_q <= {qm_q[N-2:0], 1'b1};
                    end
                end
                S_CONV: begin
                    if (qf[N-1]) begin
                        sig_q <= qf[N-1:3];
                        grd_q <= qf[2];
                        rnd_q <= qf[1];
                        stk_q <= qf[0] | rem_nz;
                    end else begin
                        sig_q <= qf[N-2:2];
                        grd_q <= qf[1];
                        rnd_q <= qf[0];
                        stk_q <= rem_nz;
                        e_q   <= e_q - 1'b1;
                    end
                end
                S_ROUND: begin
                    quo_q <= res_r;
`ifdef SRT_DIV_FLAGS_EN
                    flg_q <= flg_r;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.quotient  = quo_q;
endmodule
